// File: rtl/word_req_pkg.sv
// word_req_pkg: shared word count, address width, encoder states and clog2 helper
package word_req_pkg;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  localparam int DEFAULT_N = 16;
  localparam int DEFAULT_NO_ADDR_LINES = clog2(DEFAULT_N);
  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_e;
endpackage

// File: rtl/word_req_encoder_rr_priority_select.sv
// rr_priority_select: first set bit of req searching upward from start with wrap (ports: req, start -> found, index, onehot)
module rr_priority_select
  import word_req_pkg::*;
#(
  parameter int N = DEFAULT_N,
  parameter int W = clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] index,
  output logic [N-1:0] onehot
);
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [W-1:0]   off;
  always_comb begin
    dbl = {req, req} >> start;
    rot = dbl[N-1:0];
    off = '0;
    for (int i = N - 1; i >= 0; i--) off = rot[i] ? W'(i) : off;
    found = |req;
    index = start + off;
    onehot = found ? (N'(1) << index) : '0;
  end
endmodule

// File: rtl/word_req_encoder.sv
// word_req_encoder: sticky word requests granted round-robin as binary addresses over valid/ready (ports: clk, reset_n, word_req_lines -> addr_out/addr_valid with addr_ready, pending_count)
module word_req_encoder
  import word_req_pkg::*;
#(
  parameter int N = DEFAULT_N,
  parameter int NO_ADDR_LINES = clog2(N)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N-1:0]             word_req_lines,
  output logic [NO_ADDR_LINES-1:0] addr_out,
  output logic                     addr_valid,
  input  logic                     addr_ready,
  output logic [NO_ADDR_LINES:0]   pending_count
);
  localparam int W = NO_ADDR_LINES;
  function automatic logic [W:0] popcount(input logic [N-1:0] v);
    logic [W:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + (W+1)'(v[i]);
    return c;
  endfunction
  state_e        state_q, state_d;
  logic [N-1:0]  pending_q, pending_d, grant_mask, sel_onehot;
  logic [W-1:0]  rr_ptr_q, rr_ptr_d, addr_out_q, addr_out_d, start, sel_index;
  logic          transfer, load, sel_found;
  rr_priority_select #(.N(N), .W(W)) u_sel (
    .req(pending_q), .start(start), .found(sel_found), .index(sel_index), .onehot(sel_onehot)
  );
  // A transfer restarts the search just past the address leaving, so back-to-back reloads stay round-robin.
  always_comb begin
    transfer = (state_q == PRESENT) & addr_ready;
    start = transfer ? addr_out_q + 1'b1 : rr_ptr_q;
    load = sel_found & ((state_q == IDLE) | addr_ready);
    grant_mask = load ? sel_onehot : '0;
    pending_d = (pending_q & ~grant_mask) | word_req_lines;
    addr_out_d = load ? sel_index : addr_out_q;
    state_d = (load | ((state_q == PRESENT) & ~addr_ready)) ? PRESENT : IDLE;
    rr_ptr_d = transfer ? addr_out_q + 1'b1 : rr_ptr_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pending_q <= '0;
      rr_ptr_q <= '0;
      addr_out_q <= '0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      rr_ptr_q <= rr_ptr_d;
      addr_out_q <= addr_out_d;
    end
  end
  assign addr_out = addr_out_q;
  assign addr_valid = (state_q == PRESENT);
  assign pending_count = popcount(pending_q);
endmodule

// File: tb/tb_word_req_encoder.sv
// tb_word_req_encoder: scoreboard bench for word_req_encoder
module tb_word_req_encoder;
  logic        clk = 0;
  logic        reset_n;
  logic [15:0] word_req_lines;
  logic [3:0]  addr_out;
  logic        addr_valid;
  logic        addr_ready;
  logic [4:0]  pending_count;
  int passed = 0;
  int total = 0;
  logic [3:0] sb[$];
  logic [3:0] exp_a;

  word_req_encoder dut (
    .clk(clk), .reset_n(reset_n), .word_req_lines(word_req_lines),
    .addr_out(addr_out), .addr_valid(addr_valid), .addr_ready(addr_ready),
    .pending_count(pending_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 0;
    word_req_lines = '0;
    addr_ready = 0;
    step();
    reset_n = 1;
    sb.delete();
  endtask

  task automatic test_reset();
    reset_n = 0;
    word_req_lines = 16'hFFFF;
    addr_ready = 1;
    step();
    step();
    total++;
    if (addr_valid !== 1'b0 || addr_out !== 4'd0 || pending_count !== 5'd0)
      $display("FAIL reset_state: valid=%b addr=%0d count=%0d, required 0/0/0", addr_valid, addr_out, pending_count);
    else passed++;
    reset_n = 1;
    word_req_lines = '0;
    step();
    total++;
    if (pending_count !== 5'd0 || addr_valid !== 1'b0)
      $display("FAIL reset_release: count=%0d valid=%b, required 0/0", pending_count, addr_valid);
    else passed++;
  endtask

  task automatic test_single();
    do_reset();
    addr_ready = 1;
    word_req_lines = 16'h0020;
    sb.push_back(4'd5);
    step();
    word_req_lines = '0;
    total++;
    if (addr_valid !== 1'b0) $display("FAIL single_t1: valid=%b, required 0", addr_valid);
    else passed++;
    step();
    total++;
    if (addr_valid !== 1'b1) $display("FAIL single_t2_valid: valid=%b, required 1", addr_valid);
    else passed++;
    if (addr_valid && addr_ready && sb.size() > 0) begin
      exp_a = sb.pop_front();
      total++;
      if (addr_out !== exp_a) $display("FAIL single_addr: addr=%0d, required %0d", addr_out, exp_a);
      else passed++;
    end
    step();
    total++;
    if (addr_valid !== 1'b0 || sb.size() != 0)
      $display("FAIL single_t3: valid=%b left=%0d, required 0/0", addr_valid, sb.size());
    else passed++;
  endtask

  task automatic test_round_robin();
    logic [3:0] held;
    do_reset();
    word_req_lines = 16'h8003;
    sb.push_back(4'd0); sb.push_back(4'd1); sb.push_back(4'd15);
    step();
    word_req_lines = '0;
    step();
    held = addr_out;
    for (int i = 0; i < 3; i++) step();
    total++;
    if (addr_valid !== 1'b1 || addr_out !== held)
      $display("FAIL rr_stall_hold: valid=%b addr=%0d, required 1/%0d", addr_valid, addr_out, held);
    else passed++;
    addr_ready = 1;
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      if (addr_valid && addr_ready) begin
        exp_a = sb.pop_front();
        total++;
        if (addr_out !== exp_a) $display("FAIL rr_order: addr=%0d, required %0d", addr_out, exp_a);
        else passed++;
      end
      step();
    end
    total++;
    if (sb.size() != 0 || addr_valid !== 1'b0)
      $display("FAIL rr_drain: left=%0d valid=%b, required 0/0", sb.size(), addr_valid);
    else passed++;
    word_req_lines = 16'h8001;
    sb.push_back(4'd0); sb.push_back(4'd15);
    step();
    word_req_lines = '0;
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      if (addr_valid && addr_ready) begin
        exp_a = sb.pop_front();
        total++;
        if (addr_out !== exp_a) $display("FAIL rr_wrap_order: addr=%0d, required %0d", addr_out, exp_a);
        else passed++;
      end
      step();
    end
    total++;
    if (sb.size() != 0 || addr_valid !== 1'b0)
      $display("FAIL rr_wrap_drain: left=%0d valid=%b, required 0/0", sb.size(), addr_valid);
    else passed++;
  endtask

  task automatic test_stall_merge();
    bit stable = 1;
    int grants = 0;
    do_reset();
    word_req_lines = 16'h0008;
    sb.push_back(4'd3); sb.push_back(4'd3);
    for (int i = 0; i < 10; i++) begin
      step();
      if (i >= 2 && (addr_valid !== 1'b1 || addr_out !== 4'd3)) stable = 0;
    end
    total++;
    if (!stable) $display("FAIL stall_stable: addr=%0d valid=%b, required 3/1", addr_out, addr_valid);
    else passed++;
    total++;
    if (pending_count !== 5'd1) $display("FAIL stall_merge_count: count=%0d, required 1", pending_count);
    else passed++;
    word_req_lines = '0;
    addr_ready = 1;
    for (int c = 0; c < 8; c++) begin
      if (addr_valid && addr_ready) begin
        grants++;
        if (sb.size() > 0) begin
          exp_a = sb.pop_front();
          total++;
          if (addr_out !== exp_a) $display("FAIL stall_grant: addr=%0d, required %0d", addr_out, exp_a);
          else passed++;
        end
      end
      step();
    end
    total++;
    if (grants != 2) $display("FAIL stall_grant_count: grants=%0d, required 2", grants);
    else passed++;
  endtask

  task automatic test_set_wins();
    int grants = 0;
    do_reset();
    addr_ready = 1;
    word_req_lines = 16'h0080;
    sb.push_back(4'd7); sb.push_back(4'd7);
    step();
    step();
    word_req_lines = '0;
    total++;
    if (pending_count !== 5'd1 || addr_valid !== 1'b1)
      $display("FAIL setwins_pending: count=%0d valid=%b, required 1/1", pending_count, addr_valid);
    else passed++;
    for (int c = 0; c < 8; c++) begin
      if (addr_valid && addr_ready) begin
        grants++;
        if (sb.size() > 0) begin
          exp_a = sb.pop_front();
          total++;
          if (addr_out !== exp_a) $display("FAIL setwins_grant: addr=%0d, required %0d", addr_out, exp_a);
          else passed++;
        end
      end
      step();
    end
    total++;
    if (grants != 2) $display("FAIL setwins_grant_count: grants=%0d, required 2", grants);
    else passed++;
  endtask

  task automatic test_back_to_back_full();
    int k = 0;
    do_reset();
    addr_ready = 1;
    word_req_lines = 16'hFFFF;
    for (int i = 0; i < 16; i++) sb.push_back(4'(i));
    step();
    word_req_lines = '0;
    total++;
    if (pending_count !== 5'd16) $display("FAIL full_count: count=%0d, required 16", pending_count);
    else passed++;
    step();
    for (int c = 0; c < 16; c++) begin
      total++;
      if (!(addr_valid && addr_ready) || sb.size() == 0) begin
        $display("FAIL full_b2b: valid=%b at cycle %0d, required 1", addr_valid, c);
      end else begin
        exp_a = sb.pop_front();
        if (addr_out !== exp_a || pending_count !== 5'(15 - k))
          $display("FAIL full_grant: addr=%0d count=%0d, required %0d/%0d", addr_out, pending_count, exp_a, 15 - k);
        else passed++;
        k++;
      end
      step();
    end
    total++;
    if (addr_valid !== 1'b0) $display("FAIL full_idle: valid=%b, required 0", addr_valid);
    else passed++;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    addr_ready = 1;
    word_req_lines = 16'hFFFF;
    step();
    word_req_lines = '0;
    for (int i = 0; i < 4; i++) step();
    reset_n = 0;
    word_req_lines = 16'h0010;
    step();
    total++;
    if (addr_valid !== 1'b0 || addr_out !== 4'd0 || pending_count !== 5'd0)
      $display("FAIL midreset: valid=%b addr=%0d count=%0d, required 0/0/0", addr_valid, addr_out, pending_count);
    else passed++;
    reset_n = 1;
    word_req_lines = '0;
    step();
    step();
    total++;
    if (addr_valid !== 1'b0) $display("FAIL midreset_after: valid=%b, required 0", addr_valid);
    else passed++;
  endtask

  initial begin
    reset_n = 0;
    word_req_lines = '0;
    addr_ready = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_stall_merge();
    test_set_wins();
    test_back_to_back_full();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/word_req_encoder.md
# word_req_encoder

Converts one-hot/multi-hot word request lines back into a binary word address. It is the reverse direction of the N-to-2^N word-select decoder, and sits between the word-level request sources and the address bus that feeds that decoder. Requests are captured into a sticky pending register and granted one address at a time in round-robin order. Each address is presented on a valid/ready handshake, so no request is lost while the consumer stalls.

## Interface
- N, 16, number of words (request lines); power of two, ≥ 2
- no_addr_lines, 4, address width; must equal log2(N)
- clk  input  1  rising-edge clock; the only clock
- reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk
- word_req_lines  input  N  request per word; bit i high in a cycle raises a request for address i (sticky until granted)
- addr_out  output  no_addr_lines  granted word address; valid only while addr_valid is high
- addr_valid  output  1  addr_out holds an ungranted address
- addr_ready  input  1  consumer accepts addr_out; a transfer happens on an edge where addr_valid && addr_ready
- pending_count  output  no_addr_lines+1  number of bits set in the pending register (excludes the address on addr_out)

## Operation
- Registers:
  - pending[N-1:0]
  - rr_ptr[no_addr_lines-1:0], the round-robin start index
  - addr_out
  - addr_valid, which also acts as the state bit: IDLE = 0, PRESENT = 1
- Pending update each edge: pending <= (pending & ~grant_mask) | word_req_lines.
  - grant_mask is the one-hot of the address being loaded into addr_out at that edge.
  - Set wins over clear: a request arriving on the same edge its bit is granted stays pending.
- Selection: first set bit of pending, searching from index rr_ptr upward with wrap-around modulo N.
- IDLE:
  - pending == 0: stay in IDLE.
  - Otherwise: load addr_out with the selected index, clear that bit, set addr_valid, go to PRESENT.
- PRESENT with !addr_ready: hold addr_out and addr_valid. Pending keeps accumulating new requests.
- PRESENT with addr_ready (transfer):
  - rr_ptr <= (addr_out + 1) mod N.
  - Select again from the current pending register, searching from (addr_out + 1) mod N.
  - If a bit is found: load it, clear it, stay in PRESENT. This gives back-to-back grants.
  - If pending == 0: clear addr_valid and go to IDLE. addr_out keeps its last value.
- Repeated requests for a bit that is already pending are merged; there is no count per word.
- pending_count is combinational popcount(pending).

## Timing
- Reset (reset_n low at an edge):
  - pending = 0, rr_ptr = 0, addr_out = 0, addr_valid = 0, pending_count = 0.
  - Reset overrides any concurrent request or transfer.
  - Reset in the middle of a handshake drops the in-flight address and all pending requests.
- Request-to-valid latency: a request in cycle t is captured at the end of t. The IDLE load happens at the end of t+1, so addr_valid is high in cycle t+2.
- Throughput: one address per cycle while pending stays non-empty and addr_ready is held high.
- addr_out must not change while addr_valid && !addr_ready.
- addr_valid never drops without a transfer, except on reset.
- Wrap-around: with rr_ptr = N-1, the search order is N-1, 0, 1, …, N-2.
- Full case: all N bits pending gives pending_count = N. After the first load it reads N-1, since the in-flight address is excluded. pending_count can never exceed N.
- addr_ready while in IDLE is ignored.

## Structure
- Shared package (header): word_req_pkg holding the default N and no_addr_lines. A function clog2 is also shared with the decoder so both blocks derive no_addr_lines identically.
- One sub-module: rr_priority_select, purely combinational.
  - Inputs: req[N-1:0], start[no_addr_lines-1:0].
  - Outputs: found, index[no_addr_lines-1:0], onehot[N-1:0].
  - Implement it as a doubled-vector rotate followed by a lowest-set-bit search.
  - It is used for both the IDLE load and the back-to-back reload.
- popcount is a local function.

## Test plan
- Reset:
  - Stimulus: reset_n low for 2 cycles with word_req_lines = 16'hFFFF.
  - Required: addr_valid = 0, addr_out = 0, pending_count = 0; after release, pending_count = 0 until requests are sampled.
- Single request and latency:
  - Stimulus: word_req_lines = 16'h0020 for one cycle (t), addr_ready = 1.
  - Required: addr_out = 5 with addr_valid = 1 in cycle t+2 only, then return to IDLE.
- Round-robin order with wrap:
  - Stimulus: pulse 16'h8003, then stall addr_ready for 3 cycles, then hold it at 1.
  - Required: grant order 0, 1, 15.
  - Then pulse 16'h8001 with rr_ptr = 0 (after wrap). Required: order 0, 15.
- Stall stability and merging:
  - Stimulus: addr_ready = 0 for 10 cycles with bit 3 requested every cycle.
  - Required: addr_out is constant; pending_count = 1 (bit 3 merged); the whole burst produces exactly two grants of 3.
- Set-wins-over-clear:
  - Stimulus: re-request bit 7 on the same edge it is loaded.
  - Required: 7 is granted again on the next round.
- Full load:
  - Stimulus: pulse 16'hFFFF with addr_ready = 1.
  - Required: 16 consecutive-cycle grants 0–15 and pending_count drops from 15 to 0.
- Reset asserted mid-burst: outputs clear on the next edge.
